prga_decrypt: RTL and testbench



---
 rtl/rc4_pkg.sv | 31 +++
 rtl/ascii_char_check.sv | 14 +
 rtl/prga_decrypt.sv | 157 +++++++++++++++
 tb/tb_prga_decrypt.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: declarations shared by the RC4 stages.
//   prga_state_t       - PRGA/decrypt FSM states (one per cycle, 12 per byte)
//   ASCII_LOW/HIGH     - bounds of the lowercase letters accepted as plaintext
//   ASCII_SPACE        - the only other accepted plaintext character
//   DEFAULT_MSG_LENGTH - default number of message bytes
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_READ_I,
      ST_WAIT_I,
      ST_LATCH_I,
      ST_READ_J,
      ST_WAIT_J,
      ST_LATCH_J,
      ST_WRITE_I,
      ST_WRITE_J,
      ST_READ_F,
      ST_WAIT_F,
      ST_LATCH_F,
      ST_WRITE_OUT,
      ST_DONE
   } prga_state_t;

   localparam logic [7:0] ASCII_LOW   = 8'h61;
   localparam logic [7:0] ASCII_HIGH  = 8'h7A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int DEFAULT_MSG_LENGTH = 32;

endpackage

// File: rtl/ascii_char_check.sv
// ascii_char_check: flags a byte as readable plaintext.
//   char_i   [7:0] : candidate plaintext byte
//   is_valid       : 1 when char_i is 'a'..'z' or a space
module ascii_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_valid
);

   assign is_valid = ((char_i >= ASCII_LOW) && (char_i <= ASCII_HIGH)) ||
                     (char_i == ASCII_SPACE);

endmodule

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 pseudo-random generation + XOR decrypt stage.
// Owns the S memory port after the key schedule has finished, generates
// MSG_LENGTH keystream bytes, XORs them with the encrypted ROM bytes and
// writes the plaintext into the decrypted-result RAM.
//
// Ports:
//   CLOCK_50, reset      : clock, asynchronous active-high reset
//   start                : one-cycle start pulse, honoured in IDLE or DONE only
//   rom_data             : encrypted message bytes, held stable while busy
//   s_data_in            : S memory read data (one cycle after the address)
//   s_address_out/s_data_out/s_write_enable_out : S memory port
//   dec_address_out/dec_data_out/dec_write_enable_out : plaintext RAM port
//   busy                 : high while a run is in progress
//   done                 : level, high in DONE until the next start or reset
//   result_valid         : plaintext readable; meaningful while done is high
//
// Build option: define PRGA_VALIDITY_CHECK_EN to check every plaintext byte
// and abort the run at the first unreadable one (that byte is still written).
module prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH,
   parameter int K_W        = $clog2(MSG_LENGTH)
)
(
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        start,
   input  logic [MSG_LENGTH-1:0][7:0]  rom_data,
   input  logic [7:0]                  s_data_in,
   output logic [7:0]                  s_address_out,
   output logic [7:0]                  s_data_out,
   output logic                        s_write_enable_out,
   output logic [K_W-1:0]              dec_address_out,
   output logic [7:0]                  dec_data_out,
   output logic                        dec_write_enable_out,
   output logic                        busy,
   output logic                        done,
   output logic                        result_valid
);

   prga_state_t    state_q;
   logic [7:0]     i_q, j_q, si_q, sj_q, f_q;
   logic [K_W-1:0] k_q;
   logic           valid_q;

   logic [7:0]     j_d;
   logic [7:0]     plain_d;
   logic           last_byte;
   logic           byte_ok;

   assign j_d       = j_q + s_data_in;
   assign plain_d   = f_q ^ rom_data[k_q];
   assign last_byte = (k_q == K_W'(MSG_LENGTH - 1));

`ifdef PRGA_VALIDITY_CHECK_EN
   ascii_char_check u_char_check (
      .char_i   (plain_d),
      .is_valid (byte_ok)
   );
`else
   assign byte_ok = 1'b1;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         f_q     <= '0;
         k_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  i_q     <= 8'd1;
                  j_q     <= 8'd0;
                  k_q     <= '0;
                  valid_q <= 1'b1;
                  state_q <= ST_READ_I;
               end
            end
            ST_READ_I:  state_q <= ST_WAIT_I;
            ST_WAIT_I:  state_q <= ST_LATCH_I;
            ST_LATCH_I: begin
               si_q    <= s_data_in;
               j_q     <= j_d;
               state_q <= ST_READ_J;
            end
            ST_READ_J:  state_q <= ST_WAIT_J;
            ST_WAIT_J:  state_q <= ST_LATCH_J;
            ST_LATCH_J: begin
               sj_q    <= s_data_in;
               state_q <= ST_WRITE_I;
            end
            ST_WRITE_I: state_q <= ST_WRITE_J;
            ST_WRITE_J: state_q <= ST_READ_F;
            ST_READ_F:  state_q <= ST_WAIT_F;
            ST_WAIT_F:  state_q <= ST_LATCH_F;
            ST_LATCH_F: begin
               f_q     <= s_data_in;
               state_q <= ST_WRITE_OUT;
            end
            ST_WRITE_OUT: begin
               k_q <= k_q + 1'b1;
               i_q <= i_q + 8'd1;
               if (!byte_ok) begin
                  valid_q <= 1'b0;
               end
               state_q <= (last_byte || !byte_ok) ? ST_DONE : ST_READ_I;
            end
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   // The read address is held through the wait and latch cycles so that the
   // data is correct whether the RAM registers only its address or its output too.
   always_comb begin
      s_address_out        = '0;
      s_data_out           = '0;
      s_write_enable_out   = 1'b0;
      dec_address_out      = '0;
      dec_data_out         = '0;
      dec_write_enable_out = 1'b0;
      case (state_q)
         ST_READ_I, ST_WAIT_I, ST_LATCH_I: s_address_out = i_q;
         ST_READ_J, ST_WAIT_J, ST_LATCH_J: s_address_out = j_q;
         ST_WRITE_I: begin
            s_address_out      = i_q;
            s_data_out         = sj_q;
            s_write_enable_out = 1'b1;
         end
         ST_WRITE_J: begin
            s_address_out      = j_q;
            s_data_out         = si_q;
            s_write_enable_out = 1'b1;
         end
         ST_READ_F, ST_WAIT_F, ST_LATCH_F: s_address_out = si_q + sj_q;
         ST_WRITE_OUT: begin
            dec_address_out      = k_q;
            dec_data_out         = plain_d;
            dec_write_enable_out = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done         = (state_q == ST_DONE);
   // Without the checker valid_q is never cleared, so this reads as done.
   assign result_valid = done && valid_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt: scoreboard bench for prga_decrypt (MSG_LENGTH = 32).
// Expected S-memory and plaintext writes are queued when a run is set up;
// a negedge monitor pops and compares every write the DUT presents.
// Edge numbering: the edge that samples start is edge 1, so done is first
// seen after edge 12*bytes+1.
module tb_prga_decrypt;

   localparam int N  = 32;
   localparam int KW = 5;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic               clk;
   logic               rst;
   logic               start;
   logic [N-1:0][7:0]  rom_data;
   logic [7:0]         s_q;
   logic [7:0]         s_addr, s_wdata;
   logic               s_we;
   logic [KW-1:0]      dec_addr;
   logic [7:0]         dec_data;
   logic               dec_we;
   logic               busy, done, result_valid;

   int checks   = 0;
   int failures = 0;

   wr_t exp_dec[$];
   wr_t exp_s[$];
   logic [7:0] ks_arr [N];

   // S memory: registered address, asynchronous array read
   logic [7:0] smem [256];
   logic [7:0] s_addr_q;
   logic       init_req;
   logic       init_ff;

   prga_decrypt #(.MSG_LENGTH(N)) dut (
      .CLOCK_50             (clk),
      .reset                (rst),
      .start                (start),
      .rom_data             (rom_data),
      .s_data_in            (s_q),
      .s_address_out        (s_addr),
      .s_data_out           (s_wdata),
      .s_write_enable_out   (s_we),
      .dec_address_out      (dec_addr),
      .dec_data_out         (dec_data),
      .dec_write_enable_out (dec_we),
      .busy                 (busy),
      .done                 (done),
      .result_valid         (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (init_req) begin
         for (int a = 0; a < 256; a++) smem[a] <= init_ff ? 8'hFF : 8'(a);
      end else if (s_we) begin
         smem[s_addr] <= s_wdata;
      end
      s_addr_q <= s_addr;
   end
   assign s_q = smem[s_addr_q];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      wr_t got, e;
      if (!rst && dec_we) begin
         got = {{3'b000, dec_addr}, dec_data};
         checks++;
         if (exp_dec.size() == 0) begin
            failures++;
            $display("FAIL dec_unexpected: got addr=%0d data=%h expected no write", got.addr, got.data);
         end else begin
            e = exp_dec.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL dec_write: got addr=%0d data=%h expected addr=%0d data=%h",
                        got.addr, got.data, e.addr, e.data);
            end else begin
               $display("dec write addr=%0d data=%h", got.addr, got.data);
            end
         end
      end
      if (!rst && s_we) begin
         got = {s_addr, s_wdata};
         checks++;
         if (exp_s.size() == 0) begin
            failures++;
            $display("FAIL s_unexpected: got addr=%h data=%h expected no write", got.addr, got.data);
         end else begin
            e = exp_s.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL s_write: got addr=%h data=%h expected addr=%h data=%h",
                        got.addr, got.data, e.addr, e.data);
            end
         end
      end
   end

   // Reference RC4 PRGA. Fills ks_arr; when push is set, queues expected
   // writes from byte 'skip' onward; when chk_en is set, applies the
   // early-abort rule of the checker build.
   task automatic model(input bit ff, input int skip, input bit push, input bit chk_en,
                        output int nbytes, output bit vld);
      logic [7:0] s [256];
      logic [7:0] i, j, t, idx, ks, pt;
      for (int a = 0; a < 256; a++) s[a] = ff ? 8'hFF : 8'(a);
      i = 0; j = 0; nbytes = 0; vld = 1'b1;
      for (int k = 0; k < N; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         idx = s[i] + s[j];
         ks = s[idx];
         ks_arr[k] = ks;
         pt = ks ^ rom_data[k];
         if (push && k >= skip) begin
            exp_s.push_back({i, s[i]});
            exp_s.push_back({j, s[j]});
            exp_dec.push_back({8'(k), pt});
         end
         nbytes++;
`ifdef PRGA_VALIDITY_CHECK_EN
         if (chk_en && !(((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20))) begin
            vld = 1'b0;
            break;
         end
`endif
      end
   endtask

   task automatic init_s(input bit ff);
      init_ff  = ff;
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   // Rom chosen so that every plaintext byte is 'a'
   task automatic rom_all_a(input bit ff);
      int nb; bit v;
      model(ff, 0, 1'b0, 1'b0, nb, v);
      for (int k = 0; k < N; k++) rom_data[k] = ks_arr[k] ^ 8'h61;
   endtask

   // mode 0: plain run; 1: probe wrapped read address and pulse start while
   // busy; 2: assert reset during WRITE_I of byte 10
   task automatic run(input int exp_bytes, input bit exp_valid, input int mode);
      int edge_n;
      bit got;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      edge_n = 1;
      got    = 1'b0;
      chk("done_cleared_after_start", {31'd0, done}, 32'd0);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      while (edge_n <= 12 * N + 20) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (mode == 1) begin
            start = (edge_n == 50);
            if (edge_n == 9) begin
               chk("read_f_addr_wrap", {24'd0, s_addr}, 32'hFE);
               chk("read_f_no_wren", {31'd0, s_we}, 32'd0);
            end
         end
         if (mode == 2 && edge_n == 12 * 10 + 7) begin
            chk("write_i_wren_before_reset", {31'd0, s_we}, 32'd1);
            chk("dec_writes_before_reset", exp_dec.size(), N - 10);
            #2 rst = 1'b1;
            #1;
            chk("reset_drops_s_wren", {31'd0, s_we}, 32'd0);
            chk("reset_outputs_zero",
                {s_addr, s_wdata, dec_addr, dec_data, dec_we, busy, done, result_valid},
                32'd0);
            exp_dec.delete();
            exp_s.delete();
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         edge_n++;
      end
      start = 1'b0;
      chk("done_seen", {31'd0, got}, 32'd1);
      chk("done_edge", edge_n, 12 * exp_bytes + 1);
      chk("result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("dec_queue_drained", exp_dec.size(), 0);
      chk("s_queue_drained", exp_s.size(), 0);
      $display("run done at edge %0d result_valid=%0d", edge_n, result_valid);
   endtask

   initial begin
      int nb;
      bit v;
      rst      = 1'b1;
      start    = 1'b0;
      init_req = 1'b0;
      init_ff  = 1'b0;
      rom_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs_zero",
          {s_addr, s_wdata, s_we, dec_addr, dec_data, dec_we, busy, done, result_valid},
          32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_outputs_zero",
          {s_addr, s_wdata, s_we, dec_addr, dec_data, dec_we, busy, done, result_valid},
          32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Identity S; rom[0]=63, rom[1]=64 fall out of the all-'a' choice.
      // Bytes 0 and 1 are hand-computed, the rest come from the model.
      init_s(1'b0);
      rom_all_a(1'b0);
      chk("rom0_choice", {24'd0, rom_data[0]}, 32'h63);
      chk("rom1_choice", {24'd0, rom_data[1]}, 32'h64);
      exp_s.push_back({8'h01, 8'h01});
      exp_s.push_back({8'h01, 8'h01});
      exp_dec.push_back({8'd0, 8'h61});
      exp_s.push_back({8'h02, 8'h03});
      exp_s.push_back({8'h03, 8'h02});
      exp_dec.push_back({8'd1, 8'h61});
      model(1'b0, 2, 1'b1, 1'b1, nb, v);
      run(N, 1'b1, 0);

      // start while in DONE repeats the identical trace
      init_s(1'b0);
      model(1'b0, 0, 1'b1, 1'b1, nb, v);
      run(N, 1'b1, 0);

      // Identity S, rom all zero: first plaintext byte is 8'h02
      rom_data = '0;
      init_s(1'b0);
      model(1'b0, 0, 1'b1, 1'b1, nb, v);
`ifdef PRGA_VALIDITY_CHECK_EN
      run(1, 1'b0, 0);
`else
      run(N, 1'b1, 0);
`endif

      // S all FF: j wraps to FF, f read address wraps to FE; stray start while busy
      init_s(1'b1);
      rom_all_a(1'b1);
      model(1'b1, 0, 1'b1, 1'b1, nb, v);
      run(N, 1'b1, 1);

      // Reset in the middle of byte 10, then a clean run
      init_s(1'b0);
      rom_all_a(1'b0);
      model(1'b0, 0, 1'b1, 1'b1, nb, v);
      run(N, 1'b1, 2);
      repeat (2) @(negedge clk);
      chk("after_reset_idle", {29'd0, busy, done, result_valid}, 32'd0);
      init_s(1'b0);
      model(1'b0, 0, 1'b1, 1'b1, nb, v);
      run(N, 1'b1, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
